// File: rtl/reward_scheduler_if.sv
// Bundle between the reward scheduler and its neighbours: packet filter inputs,
// timer controls and the enable/done handshake towards the reward packer.
interface reward_scheduler_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  en;
    logic                  pkt_valid;
    logic [2:0]            fPacketType;
    logic [WORD_WIDTH-1:0] fHopsFromCH;
    logic                  iAmDestination;
    logic                  role;
    logic                  send_req;
    logic                  cf_start;
    logic                  hb_clear;
    logic                  reward_done;
    logic                  rew_en;
    logic [3:0]            rew_fbtype;
    logic [WORD_WIDTH-1:0] rew_hops;
    logic                  busy;
    logic                  hb_lock;
    logic [WORD_WIDTH-1:0] timeout_val;
    logic                  timeout_type;
    logic [6:0]            pending;

    modport master (
        output en, pkt_valid, fPacketType, fHopsFromCH, iAmDestination, role,
               send_req, cf_start, hb_clear, reward_done,
        input  rew_en, rew_fbtype, rew_hops, busy, hb_lock, timeout_val,
               timeout_type, pending
    );

    modport slave (
        input  en, pkt_valid, fPacketType, fHopsFromCH, iAmDestination, role,
               send_req, cf_start, hb_clear, reward_done,
        output rew_en, rew_fbtype, rew_hops, busy, hb_lock, timeout_val,
               timeout_type, pending
    );
endinterface

// File: rtl/reward_scheduler.sv
// Collects packet- and timer-triggered pack requests and hands them one at a time,
// lowest FBType first, to the reward packer through an enable/done handshake.
module reward_scheduler #(
    parameter int WORD_WIDTH   = 16,
    parameter int TIMEOUT_INIT = 10,
    parameter int MAX_INV_HOPS = 4
) (
    input  logic           clk,
    input  logic           nrst,
    reward_scheduler_if.slave bus
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                state, state_next;
    logic [6:0]            pending_q;
    logic                  hb_lock_q;
    logic [WORD_WIDTH-1:0] inv_hops;
    logic                  role_d;
    logic                  running;
    logic [WORD_WIDTH-1:0] timeout_val_q;
    logic                  timeout_type_q;
    logic                  rew_en_q;
    logic [3:0]            rew_fbtype_q;
    logic [WORD_WIDTH-1:0] rew_hops_q;
    logic                  busy_q;

    logic                  hb_hit;
    logic                  inv_hit;
    logic                  expire;
    logic [6:0]            set_mask;
    logic [6:0]            clear_mask;
    logic                  grant_ok;
    logic [2:0]            grant_idx;

    always_comb begin
        // A clear in the same cycle reopens the lock for this HB, which then re-locks it
        hb_hit  = bus.pkt_valid && (bus.fPacketType == 3'b000) && (!hb_lock_q || bus.hb_clear);
        inv_hit = bus.pkt_valid && (bus.fPacketType == 3'b010)
                  && (bus.fHopsFromCH < WORD_WIDTH'(MAX_INV_HOPS)) && !pending_q[1];
        expire  = running && bus.en && !bus.cf_start && (timeout_val_q == WORD_WIDTH'(1));

        set_mask = {bus.send_req,
                    expire && timeout_type_q,
                    bus.role && !role_d,
                    bus.pkt_valid && bus.iAmDestination,
                    expire && !timeout_type_q,
                    inv_hit,
                    hb_hit};

        grant_idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (pending_q[i]) grant_idx = 3'(i);
        end
        grant_ok   = (state == S_IDLE) && bus.en && (|pending_q);
        clear_mask = grant_ok ? (7'b1 << grant_idx) : 7'b0;

        state_next = state;
        case (state)
            S_IDLE: if (grant_ok) state_next = S_WAIT;
            S_WAIT: if (bus.reward_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state          <= S_IDLE;
            pending_q      <= '0;
            hb_lock_q      <= 1'b0;
            inv_hops       <= '0;
            role_d         <= 1'b0;
            running        <= 1'b0;
            timeout_val_q  <= '0;
            timeout_type_q <= 1'b0;
            rew_en_q       <= 1'b0;
            rew_fbtype_q   <= 4'hF;
            rew_hops_q     <= '0;
            busy_q         <= 1'b0;
        end else begin
            state     <= state_next;
            pending_q <= (pending_q & ~clear_mask) | set_mask;
            role_d    <= bus.role;

            if (hb_hit)            hb_lock_q <= 1'b1;
            else if (bus.hb_clear) hb_lock_q <= 1'b0;

            if (inv_hit) inv_hops <= bus.fHopsFromCH + WORD_WIDTH'(1);

            // Count holds at zero once stopped, so it never underflows
            if (bus.cf_start) begin
                timeout_val_q  <= WORD_WIDTH'(TIMEOUT_INIT);
                timeout_type_q <= bus.role;
                running        <= 1'b1;
            end else if (running && bus.en) begin
                if (timeout_val_q <= WORD_WIDTH'(1)) begin
                    timeout_val_q <= '0;
                    running       <= 1'b0;
                end else begin
                    timeout_val_q <= timeout_val_q - WORD_WIDTH'(1);
                end
            end

            rew_en_q <= grant_ok;
            if (grant_ok) begin
                rew_fbtype_q <= {1'b0, grant_idx};
                rew_hops_q   <= (grant_idx == 3'd1) ? inv_hops : '0;
                busy_q       <= 1'b1;
            end else if ((state == S_WAIT) && bus.reward_done) begin
                rew_fbtype_q <= 4'hF;
                busy_q       <= 1'b0;
            end
        end
    end

    assign bus.rew_en       = rew_en_q;
    assign bus.rew_fbtype   = rew_fbtype_q;
    assign bus.rew_hops     = rew_hops_q;
    assign bus.busy         = busy_q;
    assign bus.hb_lock      = hb_lock_q;
    assign bus.timeout_val  = timeout_val_q;
    assign bus.timeout_type = timeout_type_q;
    assign bus.pending      = pending_q;
endmodule

// File: tb/tb_reward_scheduler.sv
// Directed bench for reward_scheduler: request sources, timeout, priority order
// and the enable/done handshake, with hand-computed expectations.
module tb_reward_scheduler;
    logic clk = 1'b0;
    logic nrst;
    int   tests = 0;
    int   fails = 0;

    reward_scheduler_if #(.WORD_WIDTH(16)) bus ();

    reward_scheduler #(.WORD_WIDTH(16), .TIMEOUT_INIT(10), .MAX_INV_HOPS(4)) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pkt(input logic [2:0] ptype, input logic [15:0] hops, input logic dest);
        bus.pkt_valid      = 1'b1;
        bus.fPacketType    = ptype;
        bus.fHopsFromCH    = hops;
        bus.iAmDestination = dest;
        tick();
        bus.pkt_valid      = 1'b0;
        bus.iAmDestination = 1'b0;
    endtask

    task automatic done(input string tag);
        bus.reward_done = 1'b1;
        tick();
        bus.reward_done = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 32'h0);
        check({tag, "_fbtype"}, 32'(bus.rew_fbtype), 32'hF);
    endtask

    task automatic grant(input string tag, input logic [3:0] k);
        check({tag, "_rew_en"}, 32'(bus.rew_en), 32'h1);
        check({tag, "_fbtype"}, 32'(bus.rew_fbtype), 32'(k));
        check({tag, "_busy"}, 32'(bus.busy), 32'h1);
    endtask

    initial begin
        nrst = 1'b0;
        bus.en = 1'b0; bus.pkt_valid = 1'b0; bus.fPacketType = 3'b000;
        bus.fHopsFromCH = 16'd0; bus.iAmDestination = 1'b0; bus.role = 1'b0;
        bus.send_req = 1'b0; bus.cf_start = 1'b0; bus.hb_clear = 1'b0;
        bus.reward_done = 1'b0;
        tick(); tick();
        check("rst_rew_en", 32'(bus.rew_en), 32'h0);
        check("rst_fbtype", 32'(bus.rew_fbtype), 32'hF);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_hb_lock", 32'(bus.hb_lock), 32'h0);
        check("rst_tval", 32'(bus.timeout_val), 32'h0);
        check("rst_ttype", 32'(bus.timeout_type), 32'h0);
        check("rst_pending", 32'(bus.pending), 32'h0);
        check("rst_hops", 32'(bus.rew_hops), 32'h0);
        nrst = 1'b1; bus.en = 1'b1;
        tick();

        // HB accepted, locked, then reopened by hb_clear
        pkt(3'b000, 16'd0, 1'b0);
        check("hb1_pending", 32'(bus.pending), 32'h01);
        check("hb1_lock", 32'(bus.hb_lock), 32'h1);
        check("hb1_early", 32'(bus.rew_en), 32'h0);
        tick();
        grant("hb1", 4'd0);
        check("hb1_hops", 32'(bus.rew_hops), 32'h0);
        check("hb1_pend_clr", 32'(bus.pending), 32'h0);
        tick();
        check("hb1_pulse", 32'(bus.rew_en), 32'h0);
        check("hb1_busy_hold", 32'(bus.busy), 32'h1);
        check("hb1_fb_hold", 32'(bus.rew_fbtype), 32'h0);
        done("hb1_done");
        pkt(3'b000, 16'd0, 1'b0);
        check("hb2_pending", 32'(bus.pending), 32'h0);
        tick();
        check("hb2_rew_en", 32'(bus.rew_en), 32'h0);
        bus.hb_clear = 1'b1; tick(); bus.hb_clear = 1'b0;
        check("hbclr_lock", 32'(bus.hb_lock), 32'h0);
        pkt(3'b000, 16'd0, 1'b0);
        check("hb3_pending", 32'(bus.pending), 32'h01);
        check("hb3_lock", 32'(bus.hb_lock), 32'h1);
        tick();
        grant("hb3", 4'd0);
        done("hb3_done");

        // INV ripple and hop limit
        pkt(3'b010, 16'd2, 1'b0);
        check("inv_pending", 32'(bus.pending), 32'h02);
        tick();
        grant("inv", 4'd1);
        check("inv_hops", 32'(bus.rew_hops), 32'h3);
        done("inv_done");
        pkt(3'b010, 16'd4, 1'b0);
        check("inv4_pending", 32'(bus.pending), 32'h0);
        tick();
        check("inv4_rew_en", 32'(bus.rew_en), 32'h0);

        // MR timeout, role=0
        bus.cf_start = 1'b1; tick(); bus.cf_start = 1'b0;
        check("mr_load", 32'(bus.timeout_val), 32'd10);
        check("mr_type", 32'(bus.timeout_type), 32'h0);
        for (int i = 9; i >= 1; i--) begin
            tick();
            check("mr_count", 32'(bus.timeout_val), 32'(i));
            check("mr_no_pend", 32'(bus.pending), 32'h0);
        end
        tick();
        check("mr_zero", 32'(bus.timeout_val), 32'h0);
        check("mr_pending", 32'(bus.pending), 32'h04);
        tick();
        grant("mr", 4'd2);
        done("mr_done");
        tick();
        check("mr_hold0", 32'(bus.timeout_val), 32'h0);

        // CH timeslot timeout; the role edge also raises a CH INV
        bus.role = 1'b1; bus.cf_start = 1'b1; tick(); bus.cf_start = 1'b0;
        check("ch_load", 32'(bus.timeout_val), 32'd10);
        check("ch_type", 32'(bus.timeout_type), 32'h1);
        check("ch_inv_pend", 32'(bus.pending), 32'h10);
        tick();
        grant("chinv", 4'd4);
        check("ch_val9", 32'(bus.timeout_val), 32'd9);
        done("chinv_done");
        check("ch_val8", 32'(bus.timeout_val), 32'd8);
        for (int i = 7; i >= 1; i--) begin
            tick();
            check("ch_count", 32'(bus.timeout_val), 32'(i));
        end
        tick();
        check("ch_pending", 32'(bus.pending), 32'h20);
        tick();
        grant("chts", 4'd5);
        done("chts_done");

        // en low for 3 cycles stretches the count
        bus.role = 1'b0; bus.cf_start = 1'b1; tick(); bus.cf_start = 1'b0;
        repeat (4) tick();
        check("gap_val6", 32'(bus.timeout_val), 32'd6);
        bus.en = 1'b0;
        repeat (3) tick();
        check("gap_frozen", 32'(bus.timeout_val), 32'd6);
        bus.en = 1'b1;
        repeat (5) tick();
        check("gap_val1", 32'(bus.timeout_val), 32'd1);
        check("gap_no_pend", 32'(bus.pending), 32'h0);
        tick();
        check("gap_pending", 32'(bus.pending), 32'h04);
        tick();
        grant("gap", 4'd2);
        done("gap_done");

        // Simultaneous HB, destination packet and send request; role rises mid-wait
        bus.hb_clear = 1'b1; tick(); bus.hb_clear = 1'b0;
        bus.send_req = 1'b1;
        pkt(3'b000, 16'd0, 1'b1);
        bus.send_req = 1'b0;
        check("multi_pending", 32'(bus.pending), 32'h49);
        tick();
        grant("multi0", 4'd0);
        check("multi0_pend", 32'(bus.pending), 32'h48);
        done("multi0_done");
        tick();
        grant("multi3", 4'd3);
        bus.role = 1'b1; tick();
        check("role_pend", 32'(bus.pending), 32'h50);
        check("role_fb_hold", 32'(bus.rew_fbtype), 32'h3);
        check("role_busy", 32'(bus.busy), 32'h1);
        check("role_no_en", 32'(bus.rew_en), 32'h0);
        done("multi3_done");
        tick();
        grant("multi4", 4'd4);
        done("multi4_done");
        tick();
        grant("multi6", 4'd6);
        done("multi6_done");
        tick();
        check("role_held_en", 32'(bus.rew_en), 32'h0);
        check("role_held_pend", 32'(bus.pending), 32'h0);

        // hb_clear and an HB in the same cycle while locked
        bus.hb_clear = 1'b1;
        pkt(3'b000, 16'd0, 1'b0);
        bus.hb_clear = 1'b0;
        check("hbsame_pend", 32'(bus.pending), 32'h01);
        check("hbsame_lock", 32'(bus.hb_lock), 32'h1);
        tick();
        grant("hbsame", 4'd0);
        done("hbsame_done");

        // Reset during S_WAIT abandons the grant
        bus.send_req = 1'b1; tick(); bus.send_req = 1'b0;
        tick();
        grant("src", 4'd6);
        pkt(3'b001, 16'd0, 1'b1);
        check("src_wait_pend", 32'(bus.pending), 32'h08);
        bus.role = 1'b0; nrst = 1'b0; tick();
        check("wrst_rew_en", 32'(bus.rew_en), 32'h0);
        check("wrst_fbtype", 32'(bus.rew_fbtype), 32'hF);
        check("wrst_busy", 32'(bus.busy), 32'h0);
        check("wrst_pending", 32'(bus.pending), 32'h0);
        check("wrst_lock", 32'(bus.hb_lock), 32'h0);
        check("wrst_tval", 32'(bus.timeout_val), 32'h0);
        nrst = 1'b1; bus.reward_done = 1'b1; tick(); bus.reward_done = 1'b0;
        check("post_done_busy", 32'(bus.busy), 32'h0);
        check("post_done_fb", 32'(bus.rew_fbtype), 32'hF);
        check("post_done_en", 32'(bus.rew_en), 32'h0);
        tick();
        check("post_idle_en", 32'(bus.rew_en), 32'h0);
        check("post_idle_pend", 32'(bus.pending), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
